// File: rtl/cplx_pkg.sv
// Shared definitions for the complex-arithmetic engine.
// Contents:
//   - widths of a complex component and of the packed {re, im} word
//   - command op codes
//   - sequencer FSM state enum
//   - constant-table index names used by the register bank
//   - re/im slice and pack helpers
package cplx_pkg;

  localparam int DW   = 32;        // component width
  localparam int WW   = 2 * DW;    // packed complex word {re, im}
  localparam int OPW  = 3;
  localparam int SELW = 4;

  localparam logic [OPW-1:0] OP_ADD  = 3'b000;
  localparam logic [OPW-1:0] OP_SUB  = 3'b001;
  localparam logic [OPW-1:0] OP_MUL  = 3'b010;
  localparam logic [OPW-1:0] OP_CONJ = 3'b011;
  localparam logic [OPW-1:0] OP_NEG  = 3'b100;
  localparam logic [OPW-1:0] OP_MOV  = 3'b101;
  localparam logic [OPW-1:0] OP_SWAP = 3'b110;
  localparam logic [OPW-1:0] OP_RSV  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CAP,
    ST_EX1,
    ST_EX2,
    ST_WB
  } state_t;

  localparam logic [SELW-1:0] C_ZERO    = 4'd0;
  localparam logic [SELW-1:0] C_ONE     = 4'd1;
  localparam logic [SELW-1:0] C_J       = 4'd2;
  localparam logic [SELW-1:0] C_ONE_J   = 4'd3;
  localparam logic [SELW-1:0] C_MONE    = 4'd4;
  localparam logic [SELW-1:0] C_MJ      = 4'd5;
  localparam logic [SELW-1:0] C_MONE_MJ = 4'd6;
  localparam logic [SELW-1:0] C_MONE_J  = 4'd7;
  localparam logic [SELW-1:0] C_ONE_MJ  = 4'd8;

  function automatic logic [DW-1:0] re_of(input logic [WW-1:0] w);
    return w[WW-1:DW];
  endfunction

  function automatic logic [DW-1:0] im_of(input logic [WW-1:0] w);
    return w[DW-1:0];
  endfunction

  function automatic logic [WW-1:0] cpack(input logic [DW-1:0] re, input logic [DW-1:0] im);
    return {re, im};
  endfunction

endpackage

// File: rtl/cplx_alu_seq_if.sv
// Command bus between the instruction sequencer (master) and the
// complex-arithmetic engine (slave).
//   cmd_valid / cmd_ready : handshake, accepted when both are high
//   cmd_op                : operation code
//   cmd_srcA / cmd_srcB   : operand register or constant index
//   cmd_cnstA / cmd_cnstB : operand comes from the constant table
//   cmd_dst               : destination register
interface cplx_alu_seq_if;
  import cplx_pkg::*;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [OPW-1:0]  cmd_op;
  logic [SELW-1:0] cmd_srcA;
  logic [SELW-1:0] cmd_srcB;
  logic            cmd_cnstA;
  logic            cmd_cnstB;
  logic [SELW-1:0] cmd_dst;

  modport master (
    output cmd_valid, cmd_op, cmd_srcA, cmd_srcB, cmd_cnstA, cmd_cnstB, cmd_dst,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_srcA, cmd_srcB, cmd_cnstA, cmd_cnstB, cmd_dst,
    output cmd_ready
  );

endinterface

// File: rtl/cplx_mul.sv
// Two-phase partial-product unit for complex multiply (x * y).
//   phase  in  : 0 -> acc = x_re*y_re - x_im*y_im  (real part)
//                1 -> acc = x_re*y_im + x_im*y_re  (imag part)
//   x_re, x_im, y_re, y_im in : signed components
//   acc    out : low DW bits of the accumulated products (wraps)
// The full signed products are 2*DW wide, but only their low DW bits can
// reach acc, and those bits are identical for signed and unsigned
// multiplication, so the products are formed at DW width directly.
module cplx_mul
  import cplx_pkg::*;
(
  input  logic          phase,
  input  logic [DW-1:0] x_re,
  input  logic [DW-1:0] x_im,
  input  logic [DW-1:0] y_re,
  input  logic [DW-1:0] y_im,
  output logic [DW-1:0] acc
);

  logic [DW-1:0] mul0_b;
  logic [DW-1:0] mul1_b;
  logic [DW-1:0] prod0;
  logic [DW-1:0] prod1;

  // Multiplier 0 always takes x_re, multiplier 1 always takes x_im;
  // the phase only steers which y component each one sees.
  assign mul0_b = phase ? y_im : y_re;
  assign mul1_b = phase ? y_re : y_im;

  assign prod0 = x_re * mul0_b;
  assign prod1 = x_im * mul1_b;

  assign acc = phase ? (prod0 + prod1) : (prod0 - prod1);

endmodule

// File: rtl/cplx_alu_seq.sv
// Sequenced complex-arithmetic engine in front of the complex register bank.
//   clock, reset (async, active-low)
//   cmd                : command bus (slave side), one command at a time
//   seloutA/B, cnstA/B : bank read selects / constant-table selects
//   enrregA/B          : bank read enables (RD state only)
//   rdA, rdB           : registered bank read data
//   regwen, selwreg, endwreg, wdata : bank write port (WB state only)
//   done, err          : one-cycle completion pulse; err marks the reserved op
// Sequence: IDLE -> RD -> CAP -> EX1 [-> EX2 for MUL] -> WB -> IDLE.
module cplx_alu_seq
  import cplx_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  cplx_alu_seq_if.slave    cmd,
  output logic [SELW-1:0]  seloutA,
  output logic [SELW-1:0]  seloutB,
  output logic             cnstA,
  output logic             cnstB,
  output logic             enrregA,
  output logic             enrregB,
  input  logic [WW-1:0]    rdA,
  input  logic [WW-1:0]    rdB,
  output logic             regwen,
  output logic [SELW-1:0]  selwreg,
  output logic [1:0]       endwreg,
  output logic [WW-1:0]    wdata,
  output logic             done,
  output logic             err
);

  state_t          state_reg, state_next;
  logic [OPW-1:0]  op_reg;
  logic [SELW-1:0] src_a_reg, src_b_reg, dst_reg;
  logic            cnst_a_reg, cnst_b_reg;
  logic [WW-1:0]   op_a_reg, op_b_reg, result_reg;
  logic [WW-1:0]   alu_res;
  logic [DW-1:0]   mul_acc;
  logic            ready;
  logic            is_mul;

  assign is_mul        = (op_reg == OP_MUL);
  assign endwreg       = 2'b00;
  assign cmd.cmd_ready = ready;

  cplx_mul u_mul (
    .phase (state_reg == ST_EX2),
    .x_re  (re_of(op_a_reg)),
    .x_im  (im_of(op_a_reg)),
    .y_re  (re_of(op_b_reg)),
    .y_im  (im_of(op_b_reg)),
    .acc   (mul_acc)
  );

  // Single-cycle ops; MUL and the reserved op are handled elsewhere.
  always_comb begin
    alu_res = '0;
    case (op_reg)
      OP_ADD:  alu_res = cpack(re_of(op_a_reg) + re_of(op_b_reg), im_of(op_a_reg) + im_of(op_b_reg));
      OP_SUB:  alu_res = cpack(re_of(op_a_reg) - re_of(op_b_reg), im_of(op_a_reg) - im_of(op_b_reg));
      OP_CONJ: alu_res = cpack(re_of(op_a_reg), -im_of(op_a_reg));
      OP_NEG:  alu_res = cpack(-re_of(op_a_reg), -im_of(op_a_reg));
      OP_MOV:  alu_res = op_a_reg;
      OP_SWAP: alu_res = cpack(im_of(op_a_reg), re_of(op_a_reg));
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    enrregA    = 1'b0;
    enrregB    = 1'b0;
    seloutA    = '0;
    seloutB    = '0;
    cnstA      = 1'b0;
    cnstB      = 1'b0;
    regwen     = 1'b0;
    selwreg    = '0;
    wdata      = '0;
    done       = 1'b0;
    err        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        ready = 1'b1;
        if (cmd.cmd_valid) state_next = ST_RD;
      end
      ST_RD: begin
        enrregA    = 1'b1;
        enrregB    = 1'b1;
        seloutA    = src_a_reg;
        seloutB    = src_b_reg;
        cnstA      = cnst_a_reg;
        cnstB      = cnst_b_reg;
        state_next = ST_CAP;
      end
      ST_CAP: state_next = ST_EX1;
      ST_EX1: state_next = is_mul ? ST_EX2 : ST_WB;
      ST_EX2: state_next = ST_WB;
      ST_WB: begin
        done = 1'b1;
        if (op_reg == OP_RSV) begin
          err = 1'b1;
        end else begin
          regwen  = 1'b1;
          selwreg = dst_reg;
          wdata   = result_reg;
        end
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_reg     <= '0;
      src_a_reg  <= '0;
      src_b_reg  <= '0;
      cnst_a_reg <= 1'b0;
      cnst_b_reg <= 1'b0;
      dst_reg    <= '0;
      op_a_reg   <= '0;
      op_b_reg   <= '0;
      result_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (cmd.cmd_valid) begin
            op_reg     <= cmd.cmd_op;
            src_a_reg  <= cmd.cmd_srcA;
            src_b_reg  <= cmd.cmd_srcB;
            cnst_a_reg <= cmd.cmd_cnstA;
            cnst_b_reg <= cmd.cmd_cnstB;
            dst_reg    <= cmd.cmd_dst;
          end
        end
        ST_CAP: begin
          op_a_reg <= rdA;
          op_b_reg <= rdB;
        end
        ST_EX1: begin
          // MUL: real part now, imaginary part follows in EX2.
          if (is_mul) result_reg[WW-1:DW] <= mul_acc;
          else        result_reg          <= alu_res;
        end
        ST_EX2: result_reg[DW-1:0] <= mul_acc;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cplx_alu_seq.sv
module tb_cplx_alu_seq;
  import cplx_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  cplx_alu_seq_if cmd();

  logic [3:0]  seloutA, seloutB, selwreg;
  logic        cnstA, cnstB, enrregA, enrregB, regwen, done, err;
  logic [1:0]  endwreg;
  logic [63:0] rdA = '0, rdB = '0, wdata;

  cplx_alu_seq dut (
    .clock   (clock),
    .reset   (reset),
    .cmd     (cmd.slave),
    .seloutA (seloutA),
    .seloutB (seloutB),
    .cnstA   (cnstA),
    .cnstB   (cnstB),
    .enrregA (enrregA),
    .enrregB (enrregB),
    .rdA     (rdA),
    .rdB     (rdB),
    .regwen  (regwen),
    .selwreg (selwreg),
    .endwreg (endwreg),
    .wdata   (wdata),
    .done    (done),
    .err     (err)
  );

  typedef struct packed {
    logic [2:0]  op;
    logic [3:0]  sa;
    logic [3:0]  sb;
    logic        ca;
    logic        cb;
    logic [3:0]  dst;
    logic [63:0] data;
    logic        err;
  } vec_t;

  typedef struct {
    vec_t v;
    int   acc;
  } exp_t;

  exp_t sbq[$];
  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int wen_cnt = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Register bank model: registered reads, full-word writes.
  logic [63:0] bank [16];
  logic init_bank = 1'b0;

  function automatic logic [63:0] cval(input logic [3:0] idx);
    case (idx)
      C_ONE:     return 64'h00000001_00000000;
      C_J:       return 64'h00000000_00000001;
      C_ONE_J:   return 64'h00000001_00000001;
      C_MONE:    return 64'hFFFFFFFF_00000000;
      C_MJ:      return 64'h00000000_FFFFFFFF;
      C_MONE_MJ: return 64'hFFFFFFFF_FFFFFFFF;
      C_MONE_J:  return 64'hFFFFFFFF_00000001;
      C_ONE_MJ:  return 64'h00000001_FFFFFFFF;
      default:   return 64'h0;
    endcase
  endfunction

  always @(posedge clock) begin
    if (init_bank) begin
      for (int i = 0; i < 16; i++) bank[i] <= '0;
      bank[2]  <= 64'h00000005_00000007;
      bank[3]  <= 64'h00000001_FFFFFFFE;
      bank[6]  <= 64'h00000003_00000004;
      bank[8]  <= 64'h7FFFFFFF_00000000;
      bank[9]  <= 64'h00000002_00000000;
      bank[10] <= 64'h00000000_00000009;
      bank[11] <= 64'h80000000_12345678;
    end else if (regwen && endwreg == 2'b00) begin
      bank[selwreg] <= wdata;
    end
    if (enrregA) rdA <= cnstA ? cval(seloutA) : bank[seloutA];
    if (enrregB) rdB <= cnstB ? cval(seloutB) : bank[seloutB];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor / scoreboard consumer.
  always @(negedge clock) begin
    if (reset) begin
      if (regwen) wen_cnt++;
      if (enrregA || enrregB) begin
        if (sbq.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
        else begin
          chk("rd_sel", 64'({enrregA, enrregB, seloutA, cnstA, seloutB, cnstB}),
              64'({2'b11, sbq[0].v.sa, sbq[0].v.ca, sbq[0].v.sb, sbq[0].v.cb}));
          chk("rd_latency", 64'(cyc - sbq[0].acc), 64'd1);
        end
      end
      if (regwen && !done) chk("regwen_without_done", 64'd1, 64'd0);
      if (done) begin
        exp_t e;
        done_cnt++;
        if (sbq.size() == 0) chk("done_unexpected", 64'd1, 64'd0);
        else begin
          e = sbq.pop_front();
          chk("wb_latency", 64'(cyc - e.acc), (e.v.op == OP_MUL) ? 64'd5 : 64'd4);
          chk("wb_flags", 64'({regwen, err, endwreg}), 64'({~e.v.err, e.v.err, 2'b00}));
          if (!e.v.err) begin
            chk("wb_selwreg", 64'(selwreg), 64'(e.v.dst));
            chk("wb_wdata", wdata, e.v.data);
          end
          $display("txn op=%0d dst=%0d wdata=%h err=%0b lat=%0d", e.v.op, e.v.dst, wdata, err, cyc - e.acc);
        end
      end
    end
  end

  // Drive one command; returns the accept cycle and how many cycles ready was low.
  task automatic issue(input vec_t v, input bit hold, output int acc, output int waits);
    @(negedge clock);
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = v.op;
    cmd.cmd_srcA  = v.sa;
    cmd.cmd_srcB  = v.sb;
    cmd.cmd_cnstA = v.ca;
    cmd.cmd_cnstB = v.cb;
    cmd.cmd_dst   = v.dst;
    waits = 0;
    while (!cmd.cmd_ready && waits < 40) begin
      @(negedge clock);
      waits++;
    end
    if (!cmd.cmd_ready) chk("accept_timeout", 64'd0, 64'd1);
    acc = cyc;
    sbq.push_back('{v: v, acc: cyc});
    @(posedge clock);
    #1;
    if (!hold) cmd.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
    @(posedge clock);
    #1;
  endtask

  vec_t tbl[11];
  vec_t b2b[3];

  initial begin
    int a0, a1, w, d0;
    logic [63:0] pre;
    vec_t v;

    tbl[0]  = '{OP_ADD,  4'd2,  4'd3,  1'b0, 1'b0, 4'd4,  64'h00000006_00000005, 1'b0};
    tbl[1]  = '{OP_MUL,  4'd6,  4'd3,  1'b0, 1'b0, 4'd5,  64'h0000000B_FFFFFFFE, 1'b0};
    tbl[2]  = '{OP_MUL,  4'd8,  4'd9,  1'b0, 1'b0, 4'd12, 64'hFFFFFFFE_00000000, 1'b0};
    tbl[3]  = '{OP_SUB,  4'd10, C_ONE, 1'b0, 1'b1, 4'd10, 64'hFFFFFFFF_00000009, 1'b0};
    tbl[4]  = '{OP_CONJ, 4'd2,  4'd0,  1'b0, 1'b0, 4'd13, 64'h00000005_FFFFFFF9, 1'b0};
    tbl[5]  = '{OP_NEG,  4'd11, 4'd0,  1'b0, 1'b0, 4'd14, 64'h80000000_EDCBA988, 1'b0};
    tbl[6]  = '{OP_MOV,  4'd11, 4'd0,  1'b0, 1'b0, 4'd15, 64'h80000000_12345678, 1'b0};
    tbl[7]  = '{OP_SWAP, 4'd2,  4'd0,  1'b0, 1'b0, 4'd1,  64'h00000007_00000005, 1'b0};
    tbl[8]  = '{OP_RSV,  4'd2,  4'd3,  1'b0, 1'b0, 4'd4,  64'h0,                 1'b1};
    tbl[9]  = '{OP_MUL,  C_J,   C_J,   1'b1, 1'b1, 4'd0,  64'hFFFFFFFF_00000000, 1'b0};
    tbl[10] = '{OP_ADD,  4'd4,  4'd4,  1'b0, 1'b0, 4'd4,  64'h0000000C_0000000A, 1'b0};

    b2b[0]  = '{OP_ADD,  4'd2,  4'd3,  1'b0, 1'b0, 4'd7,  64'h00000006_00000005, 1'b0};
    b2b[1]  = '{OP_SUB,  4'd2,  4'd3,  1'b0, 1'b0, 4'd8,  64'h00000004_00000009, 1'b0};
    b2b[2]  = '{OP_SWAP, 4'd3,  4'd0,  1'b0, 1'b0, 4'd9,  64'hFFFFFFFE_00000001, 1'b0};

    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = '0;
    cmd.cmd_srcA  = '0;
    cmd.cmd_srcB  = '0;
    cmd.cmd_cnstA = 1'b0;
    cmd.cmd_cnstB = 1'b0;
    cmd.cmd_dst   = '0;

    // Reset state.
    init_bank = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctl", 64'({cmd.cmd_ready, regwen, done, err, enrregA, enrregB, cnstA, cnstB,
                          seloutA, seloutB, selwreg, endwreg}), 64'h200000);
    chk("reset_wdata", wdata, 64'h0);
    @(negedge clock);
    init_bank = 1'b0;
    reset = 1'b1;
    @(negedge clock);

    // Table-driven single commands.
    for (int i = 0; i < 11; i++) begin
      pre = bank[tbl[i].dst];
      issue(tbl[i], 1'b0, a0, w);
      wait_idle();
      chk($sformatf("bank_after_vec%0d", i), bank[tbl[i].dst], tbl[i].err ? pre : tbl[i].data);
    end

    // Back-to-back: valid held high, three commands queued.
    d0 = done_cnt;
    issue(b2b[0], 1'b1, a0, w);
    for (int k = 1; k < 3; k++) begin
      issue(b2b[k], 1'b1, a1, w);
      chk("b2b_ready_low_cycles", 64'(w), 64'd4);
      chk("b2b_accept_spacing", 64'(a1 - a0), 64'd5);
      a0 = a1;
    end
    cmd.cmd_valid = 1'b0;
    wait_idle();
    repeat (6) @(posedge clock);
    #1;
    chk("b2b_done_count", 64'(done_cnt - d0), 64'd3);

    // Reset asserted while a MUL sits in CAP.
    v = '{OP_MUL, 4'd6, 4'd3, 1'b0, 1'b0, 4'd14, 64'h0000000B_FFFFFFFE, 1'b0};
    pre = bank[14];
    wen_cnt = 0;
    issue(v, 1'b0, a0, w);   // returns #1 into RD
    @(posedge clock);        // now in CAP
    #2;
    reset = 1'b0;
    #1;
    chk("midreset_ctl", 64'({cmd.cmd_ready, regwen, done, err, enrregA, enrregB, cnstA, cnstB,
                             seloutA, seloutB, selwreg, endwreg}), 64'h200000);
    chk("midreset_wdata", wdata, 64'h0);
    sbq.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (8) @(posedge clock);
    #1;
    chk("midreset_no_regwen", 64'(wen_cnt), 64'd0);
    chk("midreset_bank_kept", bank[14], pre);

    v = '{OP_MOV, 4'd2, 4'd0, 1'b0, 1'b0, 4'd14, 64'h00000005_00000007, 1'b0};
    issue(v, 1'b0, a0, w);
    wait_idle();
    chk("post_reset_cmd", bank[14], 64'h00000005_00000007);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
